// File: rtl/mbist_march_ctrl.sv
// March C- MBIST sequencer: drives a single-port memory through six March
// elements, checks every read two cycles later and records the first failure.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LAST_ADDR  = 15,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_rdata,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [2:0]            dbg_state
);

  // Handshake: start is a level request sampled only in IDLE or DONE; busy is
  // high from the accepting edge until the run ends, then done holds until
  // the next accepted start or reset.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(LAST_ADDR);

  state_t                  state, state_nxt;
  logic [2:0]              elem;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    phase;
  logic                    drain_cnt;
  logic                    accept;
  logic                    elem_down, two_op, at_end, last_op, is_write, rd_op;
  logic [DATA_WIDTH-1:0]   exp_val;

  logic                    s1_valid, s2_valid;
  logic [DATA_WIDTH-1:0]   s1_exp, s2_exp;
  logic [ADDR_WIDTH-1:0]   s1_addr, s2_addr;
  logic [2:0]              s1_elem, s2_elem;

  function automatic logic [ADDR_WIDTH-1:0] start_addr(input logic [2:0] e);
    return (e == 3'd3 || e == 3'd4) ? LAST_A : '0;
  endfunction

  assign accept    = (state == S_IDLE || state == S_DONE) && start;
  assign elem_down = (elem == 3'd3) || (elem == 3'd4);
  assign two_op    = (elem >= 3'd1) && (elem <= 3'd4);
  assign at_end    = elem_down ? (addr == '0) : (addr == LAST_A);
  assign last_op   = (state == S_RUN) && at_end && (!two_op || phase);
  assign is_write  = (elem == 3'd0) || (two_op && phase);

  // Element write background; E5 has no write and keeps E4's zeros.
  assign mem_wdata   = (elem == 3'd1 || elem == 3'd3) ? '1 : '0;
  assign exp_val     = (elem == 3'd2 || elem == 3'd4) ? '1 : '0;
  assign mem_address = addr;
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_SETUP;
      S_SETUP:        state_nxt = S_RUN;
      S_RUN:          if (last_op) state_nxt = (elem == 3'd5) ? S_DRAIN : S_SETUP;
      S_DRAIN:        if (drain_cnt) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    mem_write_read = 1'b0;
    rd_op          = 1'b0;
    case (state)
      S_SETUP: busy = 1'b1;
      S_RUN: begin
        busy           = 1'b1;
        mem_write_read = is_write;
        rd_op          = !is_write;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Element/address walker; the next element's start address is loaded on
  // the edge into SETUP so it is already on the bus during SETUP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      elem      <= 3'd0;
      addr      <= '0;
      phase     <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            elem  <= 3'd0;
            addr  <= '0;
            phase <= 1'b0;
          end
        end
        S_RUN: begin
          drain_cnt <= 1'b0;
          if (two_op && !phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (at_end) begin
              if (elem != 3'd5) begin
                elem <= elem + 3'd1;
                addr <= start_addr(elem + 3'd1);
              end
            end else if (elem_down) begin
              addr <= addr - ADDR_WIDTH'(1);
            end else begin
              addr <= addr + ADDR_WIDTH'(1);
            end
          end
        end
        S_DRAIN: drain_cnt <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      s1_valid <= 1'b0;
      s1_exp   <= '0;
      s1_addr  <= '0;
      s1_elem  <= 3'd0;
      s2_valid <= 1'b0;
      s2_exp   <= '0;
      s2_addr  <= '0;
      s2_elem  <= 3'd0;
    end else begin
      s1_valid <= rd_op;
      s1_exp   <= exp_val;
      s1_addr  <= addr;
      s1_elem  <= elem;
      s2_valid <= s1_valid;
      s2_exp   <= s1_exp;
      s2_addr  <= s1_addr;
      s2_elem  <= s1_elem;
    end
  end

  // Stage 2 lines up with the memory's read latency; only the first
  // miscompare is captured, later ones only bump the saturating count.
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= 3'd0;
      fail_rdata <= '0;
      fail_count <= '0;
    end else if (s2_valid && (mem_rdata != s2_exp)) begin
      fail <= 1'b1;
      if (fail_count != {CNT_WIDTH{1'b1}}) fail_count <= fail_count + CNT_WIDTH'(1);
      if (!fail) begin
        fail_addr  <= s2_addr;
        fail_elem  <= s2_elem;
        fail_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: a 4-word memory model with an optional stuck-at
// bit, plus a 16-word instance with 2-bit count whose reads are all inverted.
module tb_mbist_march_ctrl;

  localparam int TW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // main instance: LAST_ADDR=3
  logic       start = 1'b0;
  logic       wr;
  logic [3:0] addr;
  logic [7:0] wdata, rdata;
  logic       busy, done, fail;
  logic [3:0] fail_addr;
  logic [2:0] fail_elem, dbg_state;
  logic [7:0] fail_rdata, fail_count;

  // saturation instance: LAST_ADDR=15, CNT_WIDTH=2
  logic       start_s = 1'b0;
  logic       wr_s;
  logic [3:0] addr_s;
  logic [7:0] wdata_s, rdata_s;
  logic       busy_s, done_s, fail_s;
  logic [3:0] fail_addr_s;
  logic [2:0] fail_elem_s, dbg_state_s;
  logic [7:0] fail_rdata_s;
  logic [1:0] fail_count_s;

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LAST_ADDR(3), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_write_read(wr), .mem_address(addr), .mem_wdata(wdata), .mem_rdata(rdata),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem),
    .fail_rdata(fail_rdata), .fail_count(fail_count), .dbg_state(dbg_state)
  );

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LAST_ADDR(15), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .mem_write_read(wr_s), .mem_address(addr_s), .mem_wdata(wdata_s), .mem_rdata(rdata_s),
    .busy(busy_s), .done(done_s), .fail(fail_s), .fail_addr(fail_addr_s), .fail_elem(fail_elem_s),
    .fail_rdata(fail_rdata_s), .fail_count(fail_count_s), .dbg_state(dbg_state_s)
  );

  // memory models: wdata captured one cycle before the write, 2-cycle read latency
  logic       fault_sa1 = 1'b0;
  logic [7:0] mem_a [0:15];
  logic [7:0] wd_q_a, rd1_a;
  logic [7:0] mem_b [0:15];
  logic [7:0] wd_q_b, rd1_b;

  always @(posedge clk) begin
    if (wr) mem_a[addr] <= wd_q_a;
    wd_q_a <= wdata;
    rd1_a  <= mem_a[addr] | ((fault_sa1 && addr == 4'd2) ? 8'h01 : 8'h00);
    rdata  <= rd1_a;
  end

  always @(posedge clk) begin
    if (wr_s) mem_b[addr_s] <= wd_q_b;
    wd_q_b  <= wdata_s;
    rd1_b   <= ~mem_b[addr_s];
    rdata_s <= rd1_b;
  end

  // scoreboard: one entry per busy cycle {busy, wr, addr, wdata, addr_checked}
  logic [TW-1:0] exp_q[$];
  logic [7:0]    rec_wdata [0:63];
  logic [3:0]    rec_addr  [0:63];
  logic          rec_wr    [0:63];

  function automatic logic [TW-1:0] ent(input logic b, input logic w, input logic [3:0] a,
                                        input logic [7:0] d, input logic c);
    return {b, w, a, d, c};
  endfunction

  task automatic build_trace();
    logic [7:0] bg;
    logic       down;
    logic [3:0] a;
    for (int e = 0; e < 6; e++) begin
      bg   = (e == 1 || e == 3) ? 8'hFF : 8'h00;
      down = (e == 3 || e == 4);
      exp_q.push_back(ent(1'b1, 1'b0, down ? 4'd3 : 4'd0, bg, 1'b1));
      for (int i = 0; i < 4; i++) begin
        a = down ? 4'(3 - i) : 4'(i);
        if (e == 0) begin
          exp_q.push_back(ent(1'b1, 1'b1, a, bg, 1'b1));
        end else if (e < 5) begin
          exp_q.push_back(ent(1'b1, 1'b0, a, bg, 1'b1));
          exp_q.push_back(ent(1'b1, 1'b1, a, bg, 1'b1));
        end else begin
          exp_q.push_back(ent(1'b1, 1'b0, a, bg, 1'b1));
        end
      end
    end
    exp_q.push_back(ent(1'b1, 1'b0, 4'd0, 8'h00, 1'b0));
    exp_q.push_back(ent(1'b1, 1'b0, 4'd0, 8'h00, 1'b0));
  endtask

  task automatic run_traced(input logic hold);
    logic [TW-1:0] e, o;
    int idx;
    build_trace();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    idx = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = {busy, wr, e[0] ? addr : 4'd0, wdata, e[0]};
      rec_wdata[idx] = wdata;
      rec_addr[idx]  = addr;
      rec_wr[idx]    = wr;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL trace[%0d]: got busy/wr/addr/wdata=%h, want %h", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({wr, addr, wdata, busy, done, fail, fail_addr, fail_elem, fail_rdata, fail_count, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_main: got outputs %h, want 0",
               {wr, addr, wdata, busy, done, fail, fail_addr, fail_elem, fail_rdata, fail_count, dbg_state});
    end
    total++;
    if ({wr_s, addr_s, wdata_s, busy_s, done_s, fail_s, fail_addr_s, fail_elem_s, fail_rdata_s, fail_count_s, dbg_state_s} !== '0) begin
      bad++;
      $display("FAIL reset_sat: got outputs %h, want 0",
               {wr_s, addr_s, wdata_s, busy_s, done_s, fail_s, fail_addr_s, fail_elem_s, fail_rdata_s, fail_count_s, dbg_state_s});
    end
    rst_n = 1'b1;
  endtask

  task automatic check_clean_done(input string name);
    @(negedge clk);
    total++;
    if ({done, busy, fail, fail_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL %s: got done=%0d busy=%0d fail=%0d count=%0d, want 1 0 0 0", name, done, busy, fail, fail_count);
    end
  endtask

  task automatic test_fault_free();
    fault_sa1 = 1'b0;
    run_traced(1'b0);
    check_clean_done("fault_free_done");
  endtask

  task automatic test_stuck_fault();
    fault_sa1 = 1'b1;
    run_traced(1'b0);
    @(negedge clk);
    total++;
    if ({done, fail} !== 2'b11) begin
      bad++;
      $display("FAIL sa1_flags: got done=%0d fail=%0d, want 1 1", done, fail);
    end
    total++;
    if (fail_addr !== 4'd2) begin bad++; $display("FAIL sa1_addr: got %0d, want 2", fail_addr); end
    total++;
    if (fail_elem !== 3'd1) begin bad++; $display("FAIL sa1_elem: got %0d, want 1", fail_elem); end
    total++;
    if (fail_rdata !== 8'h01) begin bad++; $display("FAIL sa1_rdata: got %h, want 01", fail_rdata); end
    total++;
    if (fail_count !== 8'd3) begin bad++; $display("FAIL sa1_count: got %0d, want 3", fail_count); end
    fault_sa1 = 1'b0;
  endtask

  task automatic test_op_trace();
    int changes;
    logic [3:0] e3_addr [0:7];
    logic       is_setup;
    e3_addr = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};
    run_traced(1'b0);
    check_clean_done("trace_run_done");
    // E3 ops occupy busy cycles 24..31
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({rec_addr[24 + i], rec_wr[24 + i]} !== {e3_addr[i], 1'(i % 2)}) begin
        bad++;
        $display("FAIL e3_op[%0d]: got addr=%0d wr=%0d, want addr=%0d wr=%0d",
                 i, rec_addr[24 + i], rec_wr[24 + i], e3_addr[i], i % 2);
      end
    end
    total++;
    if ({rec_wdata[6], rec_wr[7]} !== {8'hFF, 1'b1}) begin
      bad++;
      $display("FAIL e1_wdata_early: got wdata=%h wr=%0d, want FF 1", rec_wdata[6], rec_wr[7]);
    end
    changes = 0;
    for (int i = 1; i < 48; i++) begin
      is_setup = (i == 5 || i == 14 || i == 23 || i == 32 || i == 41);
      if (rec_wdata[i] !== rec_wdata[i - 1] && !is_setup) changes++;
    end
    total++;
    if (changes != 0) begin bad++; $display("FAIL wdata_stable: got %0d changes outside SETUP, want 0", changes); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, dbg_state} !== {1'b1, 3'd2}) begin
      bad++;
      $display("FAIL mid_run: got busy=%0d state=%0d, want 1 2", busy, dbg_state);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({wr, addr, wdata, busy, done, fail, fail_addr, fail_elem, fail_rdata, fail_count, dbg_state} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got outputs %h, want 0",
               {wr, addr, wdata, busy, done, fail, fail_addr, fail_elem, fail_rdata, fail_count, dbg_state});
    end
    rst_n = 1'b1;
    run_traced(1'b0);
    check_clean_done("after_reset_done");
  endtask

  task automatic test_start_held();
    int busy_cnt;
    bit seen_done;
    fault_sa1 = 1'b1;
    run_traced(1'b1);
    @(negedge clk);
    total++;
    if ({done, fail, fail_count} !== {1'b1, 1'b1, 8'd3}) begin
      bad++;
      $display("FAIL held_done: got done=%0d fail=%0d count=%0d, want 1 1 3", done, fail, fail_count);
    end
    fault_sa1 = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, fail, fail_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL held_restart: got busy=%0d done=%0d fail=%0d count=%0d, want 1 0 0 0", busy, done, fail, fail_count);
    end
    start = 1'b0;
    busy_cnt = 1;
    seen_done = 1'b0;
    for (int i = 0; i < 200 && !seen_done; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      else if (done) seen_done = 1'b1;
    end
    total++;
    if (!seen_done || busy_cnt != 48 || fail !== 1'b0) begin
      bad++;
      $display("FAIL held_rerun: got done_seen=%0d busy_cycles=%0d fail=%0d, want 1 48 0", seen_done, busy_cnt, fail);
    end
  endtask

  task automatic test_saturation();
    int busy_cnt;
    bit seen_done;
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    busy_cnt = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 400 && !seen_done; i++) begin
      @(negedge clk);
      if (busy_s) busy_cnt++;
      else if (done_s) seen_done = 1'b1;
    end
    total++;
    if (!seen_done || busy_cnt != 168) begin
      bad++;
      $display("FAIL sat_length: got done_seen=%0d busy_cycles=%0d, want 1 168", seen_done, busy_cnt);
    end
    total++;
    if ({fail_s, fail_count_s} !== {1'b1, 2'd3}) begin
      bad++;
      $display("FAIL sat_count: got fail=%0d count=%0d, want 1 3", fail_s, fail_count_s);
    end
    total++;
    if ({fail_addr_s, fail_elem_s, fail_rdata_s} !== {4'd0, 3'd1, 8'hFF}) begin
      bad++;
      $display("FAIL sat_first: got addr=%0d elem=%0d rdata=%h, want 0 1 FF", fail_addr_s, fail_elem_s, fail_rdata_s);
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_fault();
    test_op_trace();
    test_mid_reset();
    test_start_held();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
